// File: rtl/vending_pkg.sv
// Shared definitions for the vending payout path: state encoding, inventory width
// and the default hopper timeout.
package vending_pkg;

    localparam int INV_W                  = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        PAY      = 2'd2,
        FAULT    = 2'd3
    } state_t;

    // Add one extra bit of headroom so any overflow clamps at the all-ones inventory.
    function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                 input logic [INV_W-1:0] b);
        logic [INV_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[INV_W] ? {INV_W{1'b1}} : sum[INV_W-1:0];
    endfunction

endpackage

// File: rtl/coin_payout_if.sv
// Signal bundle between the vending controller / operator panel and the payout block.
interface coin_payout_if;
    import vending_pkg::*;

    logic             drop_req;
    logic             change_req;
    logic             coin_sensed;
    logic             refill_valid;
    logic [INV_W-1:0] refill_count;
    logic             fault_clr;

    logic             product_gate;
    logic             hopper_en;
    logic             done;
    logic             busy;
    logic             fault;
    logic             exact_change_only;
    logic [INV_W-1:0] coin_count;

    modport master (
        output drop_req, change_req, coin_sensed, refill_valid, refill_count, fault_clr,
        input  product_gate, hopper_en, done, busy, fault, exact_change_only, coin_count
    );

    modport slave (
        input  drop_req, change_req, coin_sensed, refill_valid, refill_count, fault_clr,
        output product_gate, hopper_en, done, busy, fault, exact_change_only, coin_count
    );

endinterface

// File: rtl/payout_timer.sv
// Hopper run timer: counts PAY cycles and flags the last allowed cycle before a fault.
module payout_timer #(
    parameter int TIMEOUT_CYCLES = vending_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int          W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Holds at the terminal value so the counter can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

    assign tc = enable && (count == LAST);

endmodule

// File: rtl/coin_payout.sv
// Product release and single Rs50 change payout controller with hopper timeout,
// fault recovery and saturating operator refill.
module coin_payout
    import vending_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int INV_INIT       = 8
) (
    input logic          clk,
    input logic          reset,
    coin_payout_if.slave bus
);

    state_t           state, state_nxt;
    logic             chg_pending, chg_nxt;
    logic             done_r, done_nxt;
    logic [INV_W-1:0] coin_count_r, count_nxt;
    logic             timer_clear, timer_en, timer_tc;

    payout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            chg_pending  <= 1'b0;
            done_r       <= 1'b0;
            coin_count_r <= INV_W'(INV_INIT);
        end else begin
            state        <= state_nxt;
            chg_pending  <= chg_nxt;
            done_r       <= done_nxt;
            coin_count_r <= count_nxt;
        end
    end

    // Refill lands in the same edge as an IDLE drop, so DISPENSE already sees the new count.
    always_comb begin
        state_nxt   = state;
        chg_nxt     = chg_pending;
        done_nxt    = 1'b0;
        count_nxt   = coin_count_r;
        timer_clear = 1'b1;
        timer_en    = 1'b0;

        if (((state == IDLE) || (state == FAULT)) && bus.refill_valid) begin
            count_nxt = sat_add(coin_count_r, bus.refill_count);
        end

        case (state)
            IDLE: begin
                if (bus.drop_req) begin
                    state_nxt = DISPENSE;
                    chg_nxt   = bus.change_req;
                end
            end
            DISPENSE: begin
                if (!chg_pending) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (coin_count_r != '0) begin
                    state_nxt = PAY;
                end else begin
                    state_nxt = FAULT;
                end
            end
            PAY: begin
                timer_clear = 1'b0;
                timer_en    = 1'b1;
                // A coin seen on the terminal cycle still counts as a successful payout.
                if (bus.coin_sensed) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    chg_nxt   = 1'b0;
                    if (coin_count_r != '0) begin
                        count_nxt = coin_count_r - INV_W'(1);
                    end
                end else if (timer_tc) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                if (bus.fault_clr) begin
                    state_nxt = IDLE;
                    chg_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.product_gate      = (state == DISPENSE);
    assign bus.hopper_en         = (state == PAY);
    assign bus.fault             = (state == FAULT);
    assign bus.busy              = (state != IDLE);
    assign bus.done              = done_r;
    assign bus.coin_count        = coin_count_r;
    assign bus.exact_change_only = (coin_count_r == '0);

endmodule
